// File: rtl/div_array_seq_arbiter_if.sv
// Bundle of the two request channels, the shared divider array hookup and the
// held response channel between the client pipelines and the sequencer.
interface div_array_seq_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_n;
  logic [7:0]  req0_d;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_n;
  logic [7:0]  req1_d;
  logic [15:0] div_n;
  logic [7:0]  div_d;
  logic [7:0]  div_q;
  logic [7:0]  div_r;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [7:0]  resp_q;
  logic [7:0]  resp_r;
  logic        resp_dz;
  logic        resp_ovf;

  modport slave (
    input  req0_valid, req0_n, req0_d, req1_valid, req1_n, req1_d,
           div_q, div_r, resp_ready,
    output req0_ready, req1_ready, div_n, div_d,
           resp_valid, resp_id, resp_q, resp_r, resp_dz, resp_ovf
  );

  modport master (
    output req0_valid, req0_n, req0_d, req1_valid, req1_n, req1_d,
           div_q, div_r, resp_ready,
    input  req0_ready, req1_ready, div_n, div_d,
           resp_valid, resp_id, resp_q, resp_r, resp_dz, resp_ovf
  );
endinterface

// File: rtl/div_array_seq_arbiter.sv
// Round-robin sequencer for one shared combinational 16/8 array divider: the
// array is treated as a multicycle path of SETTLE_CYCLES edges.
module div_array_seq_arbiter #(
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  div_array_seq_arbiter_if.slave bus,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [15:0]      dn_q, dn_d;
  logic [7:0]       dd_q, dd_d;
  logic             rv_q, rv_d;
  logic             rid_q, rid_d;
  logic             rdz_q, rdz_d;
  logic             rovf_q, rovf_d;
  logic [7:0]       rq_q, rq_d;
  logic [7:0]       rr_q, rr_d;

  logic             gnt_vld, gnt_id;
  logic [15:0]      sel_n;
  logic [7:0]       sel_d;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    gnt_vld = bus.req0_valid | bus.req1_valid;
    gnt_id  = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
    sel_n   = gnt_id ? bus.req1_n : bus.req0_n;
    sel_d   = gnt_id ? bus.req1_d : bus.req0_d;
  end

  assign bus.req0_ready = (state_q == IDLE) & gnt_vld & ~gnt_id;
  assign bus.req1_ready = (state_q == IDLE) & gnt_vld &  gnt_id;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    dn_d    = dn_q;
    dd_d    = dd_q;
    rv_d    = rv_q;
    rid_d   = rid_q;
    rdz_d   = rdz_q;
    rovf_d  = rovf_q;
    rq_d    = rq_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          dn_d   = sel_n;
          dd_d   = sel_d;
          rid_d  = gnt_id;
          last_d = gnt_id;
          // Out-of-range operations are answered without the array.
          if (sel_d == 8'h00) begin
            state_d = RESP;
            rq_d    = 8'hFF;
            rr_d    = sel_n[7:0];
            rdz_d   = 1'b1;
            rovf_d  = 1'b0;
          end else if (sel_n[15:8] >= sel_d) begin
            state_d = RESP;
            rq_d    = 8'hFF;
            rr_d    = sel_n[7:0];
            rdz_d   = 1'b0;
            rovf_d  = 1'b1;
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rq_d    = bus.div_q;
          rr_d    = bus.div_r;
          rdz_d   = 1'b0;
          rovf_d  = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Early answers enter RESP with valid still low; raise it one edge later.
        if (!rv_q) begin
          rv_d = 1'b1;
        end else if (bus.resp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      dn_q    <= '0;
      dd_q    <= '0;
      rv_q    <= 1'b0;
      rid_q   <= 1'b0;
      rdz_q   <= 1'b0;
      rovf_q  <= 1'b0;
      rq_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dn_q    <= dn_d;
      dd_q    <= dd_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      rdz_q   <= rdz_d;
      rovf_q  <= rovf_d;
      rq_q    <= rq_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.div_n      = dn_q;
  assign bus.div_d      = dd_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_id    = rid_q;
  assign bus.resp_q     = rq_q;
  assign bus.resp_r     = rr_q;
  assign bus.resp_dz    = rdz_q;
  assign bus.resp_ovf   = rovf_q;
  assign busy           = (state_q != IDLE);
endmodule
